aes_128_round_sequencer: RTL and testbench

Control block for the multicycle AES-128 encryption datapath. It accepts a plaintext/key pair over a valid/ready handshake and commands the datapath to load the initial state (state XOR key). It then steps the datapath through ROUNDS round operations, supplying the round number, round constant and final-round flag to the datapath and key schedule. Finally it presents the ciphertext over a valid/ready handshake with backpressure. It sits between the requester-facing bus interface and the round/key-expansion datapath, and owns all sequencing of that datapath.

---
 rtl/aes_128_round_sequencer.sv | 133 +++++++++++++
 tb/tb_aes_128_round_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_round_sequencer.sv
// aes_128_round_sequencer
// Sequences the multicycle AES-128 encryption datapath. It accepts a
// plaintext/key pair, has the datapath load (plaintext ^ key), runs ROUNDS
// round operations and then holds the ciphertext until the consumer takes it.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   in_valid/in_ready    input handshake (plaintext + key on datapath bus)
//   out_valid/out_ready  output handshake (ciphertext in state register)
//   abort          drop the block in flight and return to idle
//   load_state     datapath loads state <= pt ^ key, key reg <= key
//   round_en       datapath applies one round and advances the key schedule
//   round          current round 1..ROUNDS while running, 0 otherwise
//   final_round    last round (datapath skips MixColumns)
//   rcon           round constant for the current round
//   busy           block in flight (RUN or HOLD)
//   blk_count      ciphertexts delivered since reset, wraps at 2^16
module aes_128_round_sequencer #(
  parameter int ROUNDS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        abort,
  output logic        load_state,
  output logic        round_en,
  output logic [3:0]  round,
  output logic        final_round,
  output logic [7:0]  rcon,
  output logic        busy,
  output logic [15:0] blk_count
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [3:0] LAST = 4'(ROUNDS);

  state_t      state;
  logic [3:0]  rnd_q;
  logic [15:0] blk_q;

  logic in_idle;
  logic in_run;
  logic in_hold;
  logic xfer;

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1B;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Every output is masked while rst is high so the datapath sees reset
  // values during the reset cycle itself, not only after the edge.
  assign in_idle = !rst && (state == IDLE);
  assign in_run  = !rst && (state == RUN);
  assign in_hold = !rst && (state == HOLD);

  // abort overrides both handshakes; in HOLD the next block may only be
  // accepted in the same cycle the current ciphertext leaves.
  assign in_ready    = (in_idle || (in_hold && out_ready)) && !abort;
  assign load_state  = in_ready && in_valid;
  assign out_valid   = in_hold && !abort;
  assign xfer        = out_valid && out_ready;
  assign round_en    = in_run;
  assign round       = rst ? 4'd0 : rnd_q;
  assign final_round = in_run && (rnd_q == LAST);
  assign rcon        = rcon_of(round);
  assign busy        = in_run || in_hold;
  assign blk_count   = rst ? 16'd0 : blk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rnd_q <= 4'd0;
      blk_q <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (load_state) begin
            state <= RUN;
            rnd_q <= 4'd1;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            rnd_q <= 4'd0;
          end else if (rnd_q == LAST) begin
            state <= HOLD;
            rnd_q <= 4'd0;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        HOLD: begin
          if (abort) begin
            state <= IDLE;
            rnd_q <= 4'd0;
          end else if (xfer) begin
            blk_q <= blk_q + 16'd1;
            if (load_state) begin
              state <= RUN;
              rnd_q <= 4'd1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          rnd_q <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_round_sequencer.sv
// Directed bench for aes_128_round_sequencer: a ROUNDS=10 instance exercises
// latency, backpressure, back-to-back, abort, reset and wrap; a ROUNDS=2
// instance checks the short-build latency.
module tb_aes_128_round_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, abort;
  logic        in_ready, out_valid, load_state, round_en, final_round, busy;
  logic [3:0]  round;
  logic [7:0]  rcon;
  logic [15:0] blk_count;

  logic        in_valid2, out_ready2, abort2;
  logic        in_ready2, out_valid2, load_state2, round_en2, final_round2, busy2;
  logic [3:0]  round2;
  logic [7:0]  rcon2;
  logic [15:0] blk_count2;

  aes_128_round_sequencer #(.ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .abort(abort),
    .load_state(load_state), .round_en(round_en), .round(round),
    .final_round(final_round), .rcon(rcon), .busy(busy), .blk_count(blk_count)
  );

  aes_128_round_sequencer #(.ROUNDS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_ready(out_ready2), .abort(abort2),
    .load_state(load_state2), .round_en(round_en2), .round(round2),
    .final_round(final_round2), .rcon(rcon2), .busy(busy2), .blk_count(blk_count2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] rc_tab [1:15];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; in_valid2 = 1'b1; abort = 1'b0;
    mid();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_load", load_state, 0);
    chk("rst_load2", load_state2, 0);
    nxt();
    mid();
    chk("rst_round", round, 0);
    chk("rst_busy", busy, 0);
    chk("rst_blk", blk_count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rcon", rcon, 0);
    chk("rst_round_en", round_en, 0);
    nxt();
    rst = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
  endtask

  // C0: acceptance from IDLE
  task automatic accept();
    in_valid = 1'b1;
    mid();
    chk("c0_load", load_state, 1);
    chk("c0_in_ready", in_ready, 1);
    chk("c0_round", round, 0);
    chk("c0_round_en", round_en, 0);
    chk("c0_final", final_round, 0);
    chk("c0_busy", busy, 0);
    chk("c0_out_valid", out_valid, 0);
    nxt();
    in_valid = 1'b0;
  endtask

  task automatic run_rounds(input int n);
    for (int r = 1; r <= n; r++) begin
      mid();
      chk("run_round", round, r);
      chk("run_rcon", rcon, rc_tab[r]);
      chk("run_round_en", round_en, 1);
      chk("run_final", final_round, (r == 10) ? 1 : 0);
      chk("run_in_ready", in_ready, 0);
      chk("run_load", load_state, 0);
      chk("run_out_valid", out_valid, 0);
      chk("run_busy", busy, 1);
      nxt();
    end
  endtask

  initial begin
    logic seen;
    rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
               8'h1B, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; abort = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; abort2 = 1'b0;
    nxt();
    do_reset();

    // single block
    accept();
    run_rounds(10);
    mid();
    chk("c11_out_valid", out_valid, 1);
    chk("c11_in_ready", in_ready, 1);
    chk("c11_round_en", round_en, 0);
    chk("c11_busy", busy, 1);
    chk("c11_rcon", rcon, 0);
    nxt();
    mid();
    chk("c12_blk", blk_count, 1);
    chk("c12_busy", busy, 0);
    chk("c12_out_valid", out_valid, 0);
    nxt();

    // backpressure: in_valid high shows in_ready follows out_ready
    out_ready = 1'b0;
    accept();
    run_rounds(10);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_load", load_state, 0);
      chk("bp_round_en", round_en, 0);
      chk("bp_blk", blk_count, 1);
      nxt();
    end
    out_ready = 1'b1; in_valid = 1'b0;
    mid();
    chk("bp_xfer_valid", out_valid, 1);
    chk("bp_xfer_ready", in_ready, 1);
    nxt();
    mid();
    chk("bp_blk_after", blk_count, 2);
    chk("bp_idle", busy, 0);
    nxt();

    // back-to-back from a fresh reset
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    mid();
    chk("b2b_c0_load", load_state, 1);
    nxt();
    for (int b = 0; b < 3; b++) begin
      run_rounds(10);
      if (b == 2) in_valid = 1'b0;
      mid();
      chk("b2b_out_valid", out_valid, 1);
      chk("b2b_load", load_state, (b < 2) ? 1 : 0);
      chk("b2b_blk", blk_count, b);
      nxt();
    end
    mid();
    chk("b2b_blk_final", blk_count, 3);
    chk("b2b_idle", busy, 0);
    nxt();

    // abort while running
    accept();
    run_rounds(4);
    abort = 1'b1;
    mid();
    chk("abr_round5", round, 5);
    nxt();
    abort = 1'b0;
    mid();
    chk("abr_busy", busy, 0);
    chk("abr_round", round, 0);
    chk("abr_round_en", round_en, 0);
    nxt();
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      mid();
      seen = seen | out_valid;
      nxt();
    end
    chk("abr_no_out_valid", seen, 0);
    chk("abr_blk", blk_count, 3);

    // abort in HOLD with out_ready high
    accept();
    run_rounds(10);
    abort = 1'b1;
    mid();
    chk("abh_out_valid", out_valid, 0);
    chk("abh_in_ready", in_ready, 0);
    nxt();
    abort = 1'b0;
    mid();
    chk("abh_busy", busy, 0);
    chk("abh_blk", blk_count, 3);
    nxt();

    // reset in the round=7 cycle
    accept();
    run_rounds(6);
    rst = 1'b1;
    mid();
    chk("rmr_round", round, 0);
    chk("rmr_round_en", round_en, 0);
    chk("rmr_busy", busy, 0);
    chk("rmr_in_ready", in_ready, 0);
    nxt();
    rst = 1'b0;
    mid();
    chk("rmr_after_round", round, 0);
    chk("rmr_after_busy", busy, 0);
    chk("rmr_after_blk", blk_count, 0);
    chk("rmr_after_out_valid", out_valid, 0);
    chk("rmr_after_in_ready", in_ready, 1);
    nxt();
    accept();
    run_rounds(10);
    mid();
    chk("rmr_new_out_valid", out_valid, 1);
    nxt();
    mid();
    chk("rmr_new_blk", blk_count, 1);
    nxt();

    // wrap of blk_count
    force dut.blk_q = 16'hFFFF;
    nxt();
    release dut.blk_q;
    mid();
    chk("wrap_preload", blk_count, 16'hFFFF);
    nxt();
    accept();
    run_rounds(10);
    mid();
    chk("wrap_out_valid", out_valid, 1);
    nxt();
    mid();
    chk("wrap_blk", blk_count, 16'h0000);
    nxt();

    // ROUNDS=2 build: out_valid in C3
    out_ready2 = 1'b1; in_valid2 = 1'b1;
    mid();
    chk("r2_c0_load", load_state2, 1);
    chk("r2_c0_in_ready", in_ready2, 1);
    nxt();
    in_valid2 = 1'b0;
    mid();
    chk("r2_c1_round", round2, 1);
    chk("r2_c1_rcon", rcon2, 8'h01);
    chk("r2_c1_final", final_round2, 0);
    chk("r2_c1_round_en", round_en2, 1);
    nxt();
    mid();
    chk("r2_c2_round", round2, 2);
    chk("r2_c2_rcon", rcon2, 8'h02);
    chk("r2_c2_final", final_round2, 1);
    nxt();
    mid();
    chk("r2_c3_out_valid", out_valid2, 1);
    chk("r2_c3_busy", busy2, 1);
    nxt();
    mid();
    chk("r2_blk", blk_count2, 1);
    chk("r2_idle", busy2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
